// File: rtl/pea_firing_scheduler_if.sv
// Control/status bundle between the firing scheduler and its host/actor side.
// master: host and actor side (drives start/stop/fire_limit/out_req, returns enable/FC).
// slave : the scheduler (drives next_instr/invoke/busy/done/err_timeout/counters).
interface pea_firing_scheduler_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] fire_limit;
    logic             out_req;
    logic             enable;
    logic             FC;
    logic [1:0]       next_instr;
    logic             invoke;
    logic             busy;
    logic             done;
    logic             err_timeout;
    logic [CNT_W-1:0] fire_count;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output start, stop, fire_limit, out_req, enable, FC,
        input  next_instr, invoke, busy, done, err_timeout, fire_count, stall_count
    );

    modport slave (
        input  start, stop, fire_limit, out_req, enable, FC,
        output next_instr, invoke, busy, done, err_timeout, fire_count, stall_count
    );
endinterface

// File: rtl/pea_firing_scheduler.sv
// Autonomous CFDF firing sequencer for the polynomial evaluation accelerator.
// Cycles SETUP_INSTR -> INSTR (-> OUTPUT) firings: drives next_instr, waits for
// enable, pulses invoke and waits for an FC rising edge, with a watchdog.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   bus (slave)  start/stop/fire_limit/out_req/enable/FC in;
//                next_instr/invoke/busy/done/err_timeout/fire_count/stall_count out
module pea_firing_scheduler #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pea_firing_scheduler_if.slave bus
);
    localparam int unsigned WDOG_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_CHECK   = 3'd2,
        S_INVOKE  = 3'd3,
        S_WAIT_FC = 3'd4,
        S_ADVANCE = 3'd5,
        S_ERROR   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        MODE_SETUP  = 2'b00,
        MODE_INSTR  = 2'b01,
        MODE_OUTPUT = 2'b10
    } mode_e;

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [1:0]          next_instr_q, next_instr_d;
    logic                invoke_q, invoke_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0]    fire_count_q, fire_count_d;
    logic [CNT_W-1:0]    stall_count_q, stall_count_d;
    logic [CNT_W-1:0]    fire_limit_q, fire_limit_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                fc_q, fc_d;
    // Limit was reached on an INSTR firing that still owes an OUTPUT firing.
    logic                end_pending_q, end_pending_d;

    logic                fc_rise_c;
    logic [CNT_W-1:0]    fire_count_inc_c;
    logic                limit_hit_c;
    logic [WDOG_W-1:0]   wdog_inc_c;
    logic                finish_c;

    // Only a fresh FC edge counts; a level left over from the last firing does not.
    assign fc_rise_c        = bus.FC & ~fc_q;
    assign fire_count_inc_c = fire_count_q + CNT_W'(1);
    assign limit_hit_c      = (fire_limit_q != '0) && (fire_count_inc_c == fire_limit_q);
    assign wdog_inc_c       = wdog_q + WDOG_W'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        next_instr_d  = next_instr_q;
        done_d        = 1'b0;
        err_timeout_d = err_timeout_q;
        fire_count_d  = fire_count_q;
        stall_count_d = stall_count_q;
        fire_limit_d  = fire_limit_q;
        settle_cnt_d  = settle_cnt_q;
        wdog_d        = wdog_q;
        fc_d          = bus.FC;
        end_pending_d = end_pending_q;
        finish_c      = 1'b0;

        unique case (state_q)
            S_IDLE, S_ERROR: begin
                if (bus.start) begin
                    state_d       = S_SETTLE;
                    mode_d        = MODE_SETUP;
                    next_instr_d  = MODE_SETUP;
                    settle_cnt_d  = SETTLE_W'(SETTLE - 1);
                    fire_count_d  = '0;
                    stall_count_d = '0;
                    fire_limit_d  = bus.fire_limit;
                    end_pending_d = 1'b0;
                    err_timeout_d = 1'b0;
                end else if ((state_q == S_ERROR) && bus.stop) begin
                    state_d       = S_IDLE;
                    err_timeout_d = 1'b0;
                end
            end

            // next_instr was loaded on entry; hold it SETTLE cycles before sampling enable.
            S_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
                end
            end

            S_CHECK: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (bus.enable) begin
                    state_d = S_INVOKE;
                end else if (stall_count_q != '1) begin
                    stall_count_d = stall_count_q + CNT_W'(1);
                end
            end

            S_INVOKE: begin
                wdog_d  = '0;
                state_d = S_WAIT_FC;
            end

            // Watchdog counts cycles since the invoke cycle; stop is not honoured here.
            S_WAIT_FC: begin
                if (fc_rise_c) begin
                    state_d = S_ADVANCE;
                end else if (wdog_inc_c == WDOG_W'(TIMEOUT - 1)) begin
                    state_d       = S_ERROR;
                    err_timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_inc_c;
                end
            end

            S_ADVANCE: begin
                unique case (mode_q)
                    MODE_SETUP: begin
                        mode_d = MODE_INSTR;
                    end
                    MODE_INSTR: begin
                        fire_count_d = fire_count_inc_c;
                        mode_d       = bus.out_req ? MODE_OUTPUT : MODE_SETUP;
                        if (limit_hit_c) begin
                            if (bus.out_req) begin
                                end_pending_d = 1'b1;
                            end else begin
                                finish_c = 1'b1;
                            end
                        end
                    end
                    MODE_OUTPUT: begin
                        mode_d   = MODE_SETUP;
                        finish_c = end_pending_q;
                    end
                    default: begin
                        mode_d = MODE_SETUP;
                    end
                endcase

                if (finish_c) begin
                    state_d       = S_IDLE;
                    mode_d        = MODE_SETUP;
                    end_pending_d = 1'b0;
                    done_d        = 1'b1;
                end else begin
                    state_d      = S_SETTLE;
                    next_instr_d = mode_d;
                    settle_cnt_d = SETTLE_W'(SETTLE - 1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes and status follow the state being entered so they line up with it.
        invoke_d = (state_d == S_INVOKE);
        busy_d   = !((state_d == S_IDLE) || (state_d == S_ERROR));
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            mode_q        <= MODE_SETUP;
            next_instr_q  <= 2'b00;
            invoke_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            fire_count_q  <= '0;
            stall_count_q <= '0;
            fire_limit_q  <= '0;
            settle_cnt_q  <= '0;
            wdog_q        <= '0;
            fc_q          <= 1'b0;
            end_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            next_instr_q  <= next_instr_d;
            invoke_q      <= invoke_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_timeout_q <= err_timeout_d;
            fire_count_q  <= fire_count_d;
            stall_count_q <= stall_count_d;
            fire_limit_q  <= fire_limit_d;
            settle_cnt_q  <= settle_cnt_d;
            wdog_q        <= wdog_d;
            fc_q          <= fc_d;
            end_pending_q <= end_pending_d;
        end
    end

    assign bus.next_instr  = next_instr_q;
    assign bus.invoke      = invoke_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.fire_count  = fire_count_q;
    assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_pea_firing_scheduler.sv
// Directed bench for pea_firing_scheduler: an actor model answers invoke with
// FC, and expected modes per firing are queued before each run and popped as
// each invoke pulse appears.
module tb_pea_firing_scheduler;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned SETTLE    = 2;
    localparam int          ACTOR_LAT = 5;

    logic clk;
    logic rst;

    pea_firing_scheduler_if #(.CNT_W(CNT_W)) bus ();

    pea_firing_scheduler #(
        .TIMEOUT(TIMEOUT),
        .SETTLE (SETTLE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         checks;
    int         failures;
    int         cyc;
    int         inv_count;
    int         done_count;
    int         act_cnt;
    bit         actor_dead;
    bit         actor_hold;
    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard: each invoke must carry the next queued mode; done implies idle.
    always @(negedge clk) begin
        if (rst && bus.invoke) begin
            inv_count++;
            mon_exp = 2'b11;
            if (exp_q.size() != 0) mon_exp = exp_q.pop_front();
            chk("invoke_mode", {30'd0, bus.next_instr}, {30'd0, mon_exp});
        end
        if (rst && bus.done) begin
            done_count++;
            chk("done_busy", {31'd0, bus.busy}, 0);
        end
    end

    // Actor: FC rises ACTOR_LAT cycles after invoke; pulse unless held, never if dead.
    initial begin
        bus.FC  = 1'b0;
        act_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bus.FC  = 1'b0;
                act_cnt = 0;
            end else if (bus.invoke) begin
                act_cnt = ACTOR_LAT;
                if (!actor_hold) bus.FC = 1'b0;
            end else if (act_cnt > 0) begin
                act_cnt--;
                if (act_cnt == 0 && !actor_dead) bus.FC = 1'b1;
                else if (!actor_hold) bus.FC = 1'b0;
            end else if (!actor_hold) begin
                bus.FC = 1'b0;
            end
        end
    end

    task automatic start_run(input logic [CNT_W-1:0] lim, input logic oreq);
        bus.fire_limit = lim;
        bus.out_req    = oreq;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic wait_invoke(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.invoke && n < budget);
        chk(tag, {31'd0, bus.invoke}, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, bus.busy}, 0);
        tick();
    endtask

    task automatic wait_err(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.err_timeout && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, bus.err_timeout}, 1);
    endtask

    initial begin
        int inv0;
        int dn0;
        int t_inv;

        checks = 0; failures = 0; cyc = 0; inv_count = 0; done_count = 0;
        rst = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.fire_limit = '0;
        bus.out_req = 1'b0; bus.enable = 1'b1;
        actor_dead = 1'b0; actor_hold = 1'b0;
        tick(); tick();

        // Reset values
        chk("rst_next_instr", {30'd0, bus.next_instr}, 0);
        chk("rst_invoke", {31'd0, bus.invoke}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_err", {31'd0, bus.err_timeout}, 0);
        chk("rst_fire_count", {16'd0, bus.fire_count}, 0);
        chk("rst_stall_count", {16'd0, bus.stall_count}, 0);
        rst = 1'b1;
        tick(); tick();
        chk("idle_busy", {31'd0, bus.busy}, 0);

        // Basic run: two INSTR firings, plus a start while busy that must be ignored
        exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        inv0 = inv_count; dn0 = done_count;
        start_run(16'd2, 1'b0);
        chk("basic_busy", {31'd0, bus.busy}, 1);
        wait_invoke("basic_inv1", 50);
        bus.fire_limit = 16'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_idle("basic_idle", 300);
        chk("basic_invokes", inv_count - inv0, 4);
        chk("basic_done", done_count - dn0, 1);
        chk("basic_fire_count", {16'd0, bus.fire_count}, 2);

        // Output mode: SETUP, INSTR, OUTPUT then done
        exp_q.push_back(2'b00); exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        inv0 = inv_count; dn0 = done_count;
        start_run(16'd1, 1'b1);
        wait_idle("out_idle", 300);
        chk("out_invokes", inv_count - inv0, 3);
        chk("out_done", done_count - dn0, 1);
        chk("out_fire_count", {16'd0, bus.fire_count}, 1);
        chk("out_next_instr_hold", {30'd0, bus.next_instr}, 2);
        bus.out_req = 1'b0;

        // Enable stall: 2 SETTLE cycles then 7 CHECK cycles with enable low
        exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        bus.enable = 1'b0;
        start_run(16'd1, 1'b0);
        repeat (9) tick();
        chk("stall_no_invoke", {31'd0, bus.invoke}, 0);
        bus.enable = 1'b1;
        tick();
        chk("stall_invoke_latency", {31'd0, bus.invoke}, 1);
        wait_idle("stall_idle", 300);
        chk("stall_count", {16'd0, bus.stall_count}, 7);
        chk("stall_fire_count", {16'd0, bus.fire_count}, 1);

        // Watchdog: actor dies on the INSTR firing
        exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        start_run(16'd1, 1'b0);
        wait_invoke("wd_inv1", 50);
        wait_invoke("wd_inv2", 50);
        actor_dead = 1'b1;
        t_inv = cyc;
        wait_err("wd_err", 40);
        chk("wd_latency", cyc - t_inv, 16);
        chk("wd_busy", {31'd0, bus.busy}, 0);
        chk("wd_next_instr_hold", {30'd0, bus.next_instr}, 1);
        chk("wd_fire_count", {16'd0, bus.fire_count}, 0);
        tick();
        chk("wd_err_sticky", {31'd0, bus.err_timeout}, 1);
        chk("wd_err_invoke", {31'd0, bus.invoke}, 0);
        actor_dead = 1'b0;
        exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        dn0 = done_count;
        start_run(16'd1, 1'b0);
        chk("wd_restart_err_clr", {31'd0, bus.err_timeout}, 0);
        chk("wd_restart_mode", {30'd0, bus.next_instr}, 0);
        chk("wd_restart_busy", {31'd0, bus.busy}, 1);
        wait_idle("wd_restart_idle", 300);
        chk("wd_restart_done", done_count - dn0, 1);

        // Held FC: the level from the first firing must not complete the second
        actor_hold = 1'b1;
        exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        start_run(16'd1, 1'b0);
        wait_invoke("hold_inv1", 50);
        wait_invoke("hold_inv2", 50);
        t_inv = cyc;
        wait_err("hold_err", 40);
        chk("hold_latency", cyc - t_inv, 16);
        chk("hold_fire_count", {16'd0, bus.fire_count}, 0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("hold_stop_err_clr", {31'd0, bus.err_timeout}, 0);
        chk("hold_stop_busy", {31'd0, bus.busy}, 0);
        actor_hold = 1'b0;
        tick(); tick();

        // Stop during WAIT_FC: firing completes, ADVANCE runs, halt at next CHECK
        exp_q.push_back(2'b00);
        inv0 = inv_count; dn0 = done_count;
        start_run(16'd0, 1'b0);
        wait_invoke("stop_inv", 50);
        bus.stop = 1'b1;
        tick(); tick();
        chk("stop_wait_busy", {31'd0, bus.busy}, 1);
        wait_idle("stop_idle", 100);
        bus.stop = 1'b0;
        chk("stop_invokes", inv_count - inv0, 1);
        chk("stop_no_done", done_count - dn0, 0);
        chk("stop_advanced_mode", {30'd0, bus.next_instr}, 1);

        // Async reset in the middle of the second INSTR firing
        exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        start_run(16'd0, 1'b0);
        repeat (4) wait_invoke("arst_inv", 50);
        tick(); tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 0);
        chk("arst_invoke", {31'd0, bus.invoke}, 0);
        chk("arst_next_instr", {30'd0, bus.next_instr}, 0);
        chk("arst_fire_count", {16'd0, bus.fire_count}, 0);
        chk("arst_done", {31'd0, bus.done}, 0);
        tick();
        rst = 1'b1;
        inv0 = inv_count;
        repeat (10) tick();
        chk("arst_stay_idle", {31'd0, bus.busy}, 0);
        chk("arst_no_invoke", inv_count - inv0, 0);

        // A normal run still works after the reset
        exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        dn0 = done_count;
        start_run(16'd1, 1'b0);
        wait_idle("post_idle", 300);
        chk("post_done", done_count - dn0, 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
